line_print_sequencer: RTL and testbench

// Sequences printing of a range of transform-table lines to a byte stream (UART/display).
// Per line: fetches the {len,start} pointer entry, reads the char-pair memory twice and emits
// lhs chars, SEP_CHAR, rhs chars, then CR LF.

---
 rtl/line_print_sequencer_pkg.sv | 52 +++++
 rtl/line_print_sequencer_out_stage.sv | 40 ++++
 rtl/line_print_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_line_print_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_print_sequencer_pkg.sv
// Shared types and constants for the line print sequencer: FSM states, output pass
// selector and the fixed datapath widths.
package lps_pkg;

    localparam int LINE_W = 8;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PTR_WAIT  = 4'd1,
        S_PTR_LATCH = 4'd2,
        S_CHAR_WAIT = 4'd3,
        S_CHAR_CAP  = 4'd4,
        S_EMIT      = 4'd5,
        S_SEP       = 4'd6,
        S_EOL_CR    = 4'd7,
        S_EOL_LF    = 4'd8,
        S_NEXT      = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    typedef enum logic {
        PASS_LHS = 1'b0,
        PASS_RHS = 1'b1
    } pass_t;

    // First end-of-line state; the CR beat is skipped when disabled.
    function automatic state_t eol_entry(input logic cr_en);
        state_t s;
        if (cr_en) begin
            s = S_EOL_CR;
        end else begin
            s = S_EOL_LF;
        end
        return s;
    endfunction

    function automatic logic [7:0] eol_char(input logic cr_en);
        logic [7:0] c;
        if (cr_en) begin
            c = CHAR_CR;
        end else begin
            c = CHAR_LF;
        end
        return c;
    endfunction

endpackage

// File: rtl/line_print_sequencer_out_stage.sv
// Output holding register: a loaded byte stays valid and stable until the sink
// accepts it or the stage is cleared.
module lps_out_stage
    import lps_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_accept,
    input  logic       i_clear,
    output logic       o_valid,
    output logic [7:0] o_data
);

    logic       r_valid;
    logic [7:0] r_data;

    // Clear beats load so an abandoned beat never reappears; load beats accept so a
    // back-to-back beat can follow an accepted one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_accept) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/line_print_sequencer.sv
// Prints a range of transform-table lines as "lhs chars, separator, rhs chars, EOL",
// driving the pointer ROM and char memory read ports (both two-cycle latency).
module line_print_sequencer
    import lps_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR  = 8'h3D,
    parameter bit         EOL_CR_EN = 1'b1
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [LINE_W-1:0]       i_cmd_first,
    input  logic [LINE_W-1:0]       i_cmd_count,
    input  logic                    i_abort,
    output logic [LINE_W-1:0]       o_ptr_idx,
    input  logic [LEN_W+ADDR_W-1:0] i_ptr_data,
    output logic [ADDR_W-1:0]       o_mem_addr,
    input  logic [15:0]             i_mem_dout,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [7:0]              o_out_data,
    output logic                    o_busy,
    output logic                    o_done
);

    state_t              r_state;
    state_t              w_next;
    logic [LINE_W-1:0]   r_ptr_idx;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_start;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_rem;
    logic [LINE_W-1:0]   r_lines_left;
    pass_t               r_pass;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_out_valid;
    logic [7:0]          w_out_data;
    logic                w_accept;
    logic                w_abort;
    logic                w_load;
    logic [7:0]          w_load_data;
    logic                w_take;
    logic                w_latch;
    logic                w_rem_dec;
    logic                w_addr_inc;
    logic                w_sep_done;
    logic                w_line_next;
    logic                w_ptr_inc;
    logic [LEN_W-1:0]    w_ptr_len;
    logic [ADDR_W-1:0]   w_ptr_start;

    assign w_ptr_len   = i_ptr_data[LEN_W+ADDR_W-1:ADDR_W];
    assign w_ptr_start = i_ptr_data[ADDR_W-1:0];
    assign w_accept    = w_out_valid && i_out_ready;
    assign w_abort     = i_abort && (r_state != S_IDLE) && (r_state != S_DONE);

    // Next-state decode plus one-cycle datapath strobes; abort overrides everything.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_take      = 1'b0;
        w_latch     = 1'b0;
        w_rem_dec   = 1'b0;
        w_addr_inc  = 1'b0;
        w_sep_done  = 1'b0;
        w_line_next = 1'b0;
        w_ptr_inc   = 1'b0;
        if (w_abort) begin
            w_next = S_DONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        w_take = 1'b1;
                        if (i_cmd_count == 8'd0) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_PTR_WAIT;
                        end
                    end else begin
                        w_next = S_IDLE;
                    end
                end
                S_PTR_WAIT: w_next = S_PTR_LATCH;
                S_PTR_LATCH: begin
                    w_latch = 1'b1;
                    if (w_ptr_len == 10'd0) begin
                        w_next      = S_SEP;
                        w_load      = 1'b1;
                        w_load_data = SEP_CHAR;
                    end else begin
                        w_next = S_CHAR_WAIT;
                    end
                end
                S_CHAR_WAIT: w_next = S_CHAR_CAP;
                S_CHAR_CAP: begin
                    w_next = S_EMIT;
                    w_load = 1'b1;
                    if (r_pass == PASS_RHS) begin
                        w_load_data = i_mem_dout[7:0];
                    end else begin
                        w_load_data = i_mem_dout[15:8];
                    end
                end
                S_EMIT: begin
                    if (w_accept) begin
                        w_rem_dec = 1'b1;
                        if (r_rem > 10'd1) begin
                            w_addr_inc = 1'b1;
                            w_next     = S_CHAR_WAIT;
                        end else if (r_pass == PASS_LHS) begin
                            w_next      = S_SEP;
                            w_load      = 1'b1;
                            w_load_data = SEP_CHAR;
                        end else begin
                            w_next      = eol_entry(EOL_CR_EN);
                            w_load      = 1'b1;
                            w_load_data = eol_char(EOL_CR_EN);
                        end
                    end else begin
                        w_next = S_EMIT;
                    end
                end
                S_SEP: begin
                    if (w_accept) begin
                        w_sep_done = 1'b1;
                        if (r_len == 10'd0) begin
                            w_next      = eol_entry(EOL_CR_EN);
                            w_load      = 1'b1;
                            w_load_data = eol_char(EOL_CR_EN);
                        end else begin
                            w_next = S_CHAR_WAIT;
                        end
                    end else begin
                        w_next = S_SEP;
                    end
                end
                S_EOL_CR: begin
                    if (w_accept) begin
                        w_next      = S_EOL_LF;
                        w_load      = 1'b1;
                        w_load_data = CHAR_LF;
                    end else begin
                        w_next = S_EOL_CR;
                    end
                end
                S_EOL_LF: begin
                    if (w_accept) begin
                        w_next = S_NEXT;
                    end else begin
                        w_next = S_EOL_LF;
                    end
                end
                S_NEXT: begin
                    w_line_next = 1'b1;
                    if (r_lines_left != 8'd1) begin
                        w_ptr_inc = 1'b1;
                        w_next    = S_PTR_WAIT;
                    end else begin
                        w_next = S_DONE;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Line/char counters and the two memory address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_idx    <= 8'd0;
            r_mem_addr   <= 10'h3FF;
            r_start      <= 10'd0;
            r_len        <= 10'd0;
            r_rem        <= 10'd0;
            r_lines_left <= 8'd0;
            r_pass       <= PASS_LHS;
        end else if (w_take) begin
            r_ptr_idx    <= i_cmd_first;
            r_lines_left <= i_cmd_count;
        end else if (w_latch) begin
            r_start    <= w_ptr_start;
            r_len      <= w_ptr_len;
            r_rem      <= w_ptr_len;
            r_mem_addr <= w_ptr_start;
            r_pass     <= PASS_LHS;
        end else if (w_rem_dec) begin
            r_rem <= r_rem - 10'd1;
            if (w_addr_inc) begin
                r_mem_addr <= r_mem_addr + 10'd1;
            end else begin
                r_mem_addr <= r_mem_addr;
            end
        end else if (w_sep_done) begin
            r_pass     <= PASS_RHS;
            r_rem      <= r_len;
            r_mem_addr <= r_start;
        end else if (w_line_next) begin
            r_lines_left <= r_lines_left - 8'd1;
            if (w_ptr_inc) begin
                r_ptr_idx <= r_ptr_idx + 8'd1;
            end else begin
                r_ptr_idx <= r_ptr_idx;
            end
        end else begin
            r_rem <= r_rem;
        end
    end

    // Status flags registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
        end
    end

    lps_out_stage u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_accept (w_accept),
        .i_clear  (w_abort),
        .o_valid  (w_out_valid),
        .o_data   (w_out_data)
    );

    assign o_cmd_ready = r_cmd_ready;
    assign o_ptr_idx   = r_ptr_idx;
    assign o_mem_addr  = r_mem_addr;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = w_out_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_line_print_sequencer.sv
// Directed bench for line_print_sequencer: table of commands with expected byte,
// pointer-index and address sequences, plus abort and mid-command reset sequences.
module tb_line_print_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_first = 8'd0;
    logic [7:0]  i_cmd_count = 8'd0;
    logic        i_abort = 1'b0;
    logic [7:0]  o_ptr_idx;
    logic [19:0] i_ptr_data;
    logic [9:0]  o_mem_addr;
    logic [15:0] i_mem_dout;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [7:0]  o_out_data;
    logic        o_busy;
    logic        o_done;

    line_print_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_first (i_cmd_first),
        .i_cmd_count (i_cmd_count),
        .i_abort     (i_abort),
        .o_ptr_idx   (o_ptr_idx),
        .i_ptr_data  (i_ptr_data),
        .o_mem_addr  (o_mem_addr),
        .i_mem_dout  (i_mem_dout),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Memory models: one register stage, so data for a new address shows up in the
    // second cycle after the address changes.
    logic [19:0] rom  [256];
    logic [15:0] cmem [1024];
    always @(posedge clk) begin
        i_ptr_data <= rom[o_ptr_idx];
        i_mem_dout <= cmem[o_mem_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]       first;
        logic [7:0]       count;
        logic             slow;
        int               lat;
        int               nb;
        logic [0:9][7:0]  b;
        int               na;
        logic [0:5][9:0]  a;
        int               np;
        logic [0:1][7:0]  p;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] first, input logic [7:0] count,
                                input logic slow, input int lat, input int nb,
                                input logic [0:9][7:0] b, input int na,
                                input logic [0:5][9:0] a, input int np,
                                input logic [0:1][7:0] p);
        vec_t v;
        v.first = first; v.count = count; v.slow = slow; v.lat = lat;
        v.nb = nb; v.b = b; v.na = na; v.a = a; v.np = np; v.p = p;
        return v;
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        logic [7:0] got [$];
        logic [9:0] ga [$];
        logic [7:0] gp [$];
        logic [7:0] prev_ptr;
        logic [9:0] prev_addr;
        logic [7:0] pd;
        logic       pv;
        logic       pr;
        logic       rdy;
        int         first_k;
        int         done_k;
        int         dones;
        int         bad_hold;
        int         extra_beats;
        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready", vi), 32'(o_cmd_ready), 32'd1);
        i_cmd_first = v.first;
        i_cmd_count = v.count;
        i_cmd_valid = 1'b1;
        i_out_ready = 1'b0;
        prev_ptr = o_ptr_idx; prev_addr = o_mem_addr;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        first_k = -1; done_k = -1; dones = 0; bad_hold = 0; extra_beats = 0;
        for (int k = 1; k <= 400 && done_k < 0; k++) begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            if (o_ptr_idx != prev_ptr) begin gp.push_back(o_ptr_idx); prev_ptr = o_ptr_idx; end
            if (o_mem_addr != prev_addr) begin ga.push_back(o_mem_addr); prev_addr = o_mem_addr; end
            if (o_out_valid && first_k < 0) first_k = k;
            if (pv && !pr && (!o_out_valid || o_out_data != pd)) bad_hold++;
            if (o_done) begin dones++; done_k = k; end
            rdy = v.slow ? ((k % 4) == 0) : 1'b1;
            i_out_ready = rdy;
            if (o_out_valid && rdy) got.push_back(o_out_data);
            pv = o_out_valid; pr = rdy; pd = o_out_data;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (o_out_valid) extra_beats++;
        end
        i_out_ready = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), 32'(done_k > 0), 32'd1);
        chk($sformatf("v%0d_done_pulses", vi), 32'(dones), 32'd1);
        chk($sformatf("v%0d_no_beats_after_done", vi), 32'(extra_beats), 32'd0);
        chk($sformatf("v%0d_ready_after", vi), 32'(o_cmd_ready), 32'd1);
        chk($sformatf("v%0d_nbytes", vi), 32'(got.size()), 32'(v.nb));
        for (int i = 0; i < v.nb && i < got.size(); i++)
            chk($sformatf("v%0d_byte%0d", vi, i), 32'(got[i]), 32'(v.b[i]));
        chk($sformatf("v%0d_naddr", vi), 32'(ga.size()), 32'(v.na));
        for (int i = 0; i < v.na && i < ga.size(); i++)
            chk($sformatf("v%0d_addr%0d", vi, i), 32'(ga[i]), 32'(v.a[i]));
        chk($sformatf("v%0d_nptr", vi), 32'(gp.size()), 32'(v.np));
        for (int i = 0; i < v.np && i < gp.size(); i++)
            chk($sformatf("v%0d_ptr%0d", vi, i), 32'(gp[i]), 32'(v.p[i]));
        chk($sformatf("v%0d_hold_stable", vi), 32'(bad_hold), 32'd0);
        if (v.lat >= 0)
            chk($sformatf("v%0d_first_latency", vi), 32'(first_k), 32'(v.lat));
        if (v.count == 8'd0)
            chk($sformatf("v%0d_zero_count_done", vi), 32'(done_k >= 1 && done_k <= 2), 32'd1);
    endtask

    vec_t vt [6];

    initial begin
        int k;
        int beats;
        for (int i = 0; i < 256; i++) rom[i] = 20'h0;
        for (int i = 0; i < 1024; i++) cmem[i] = 16'h0;
        rom[3]   = {10'd2, 10'h010};
        rom[255] = {10'd1, 10'h020};
        rom[0]   = {10'd1, 10'h030};
        rom[5]   = {10'd0, 10'h040};
        rom[7]   = {10'd3, 10'h3FF};
        cmem[10'h010] = 16'h4142; cmem[10'h011] = 16'h4344;
        cmem[10'h020] = 16'h5859; cmem[10'h030] = 16'h6162;
        cmem[10'h3FF] = 16'h3132; cmem[10'h000] = 16'h3334; cmem[10'h001] = 16'h3536;

        vt[0] = mk(8'd3, 8'd1, 1'b0, 5, 7,
                   {8'h41, 8'h43, 8'h3D, 8'h42, 8'h44, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00},
                   4, {10'h010, 10'h011, 10'h010, 10'h011, 10'h000, 10'h000},
                   1, {8'd3, 8'd0});
        vt[1] = mk(8'd255, 8'd2, 1'b0, 5, 10,
                   {8'h58, 8'h3D, 8'h59, 8'h0D, 8'h0A, 8'h61, 8'h3D, 8'h62, 8'h0D, 8'h0A},
                   2, {10'h020, 10'h030, 10'h000, 10'h000, 10'h000, 10'h000},
                   2, {8'd255, 8'd0});
        vt[2] = mk(8'd5, 8'd1, 1'b0, 3, 3,
                   {8'h3D, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1, {10'h040, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000},
                   1, {8'd5, 8'd0});
        vt[3] = mk(8'd3, 8'd1, 1'b1, -1, 7,
                   {8'h41, 8'h43, 8'h3D, 8'h42, 8'h44, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00},
                   4, {10'h010, 10'h011, 10'h010, 10'h011, 10'h000, 10'h000},
                   1, {8'd3, 8'd0});
        vt[4] = mk(8'd7, 8'd1, 1'b0, 5, 9,
                   {8'h31, 8'h33, 8'h35, 8'h3D, 8'h32, 8'h34, 8'h36, 8'h0D, 8'h0A, 8'h00},
                   6, {10'h3FF, 10'h000, 10'h001, 10'h3FF, 10'h000, 10'h001},
                   1, {8'd7, 8'd0});
        vt[5] = mk(8'd3, 8'd0, 1'b0, -1, 0,
                   {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   0, {10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000},
                   1, {8'd3, 8'd0});

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_out_data",  32'(o_out_data),  32'h00);
        chk("rst_ptr_idx",   32'(o_ptr_idx),   32'h00);
        chk("rst_mem_addr",  32'(o_mem_addr),  32'h3FF);
        chk("rst_busy",      32'(o_busy),      32'd0);
        chk("rst_done",      32'(o_done),      32'd0);
        rst = 1'b0;

        for (int vi = 0; vi < 6; vi++) run_vec(vi, vt[vi]);

        // Abort in EMIT with the sink ready in the same cycle.
        @(negedge clk);
        i_cmd_first = 8'd3; i_cmd_count = 8'd1; i_cmd_valid = 1'b1; i_out_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            k++;
        end while (!o_out_valid && k < 20);
        chk("abort_reached_emit", 32'(o_out_valid), 32'd1);
        chk("abort_first_byte", 32'(o_out_data), 32'h41);
        chk("abort_busy", 32'(o_busy), 32'd1);
        i_abort = 1'b1; i_out_ready = 1'b1;
        @(negedge clk);
        i_abort = 1'b0; i_out_ready = 1'b0;
        chk("abort_valid_dropped", 32'(o_out_valid), 32'd0);
        chk("abort_done_pulse", 32'(o_done), 32'd1);
        @(negedge clk);
        chk("abort_done_cleared", 32'(o_done), 32'd0);
        chk("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("abort_not_busy", 32'(o_busy), 32'd0);

        // Reset in the middle of a command.
        i_cmd_first = 8'd7; i_cmd_count = 8'd1; i_cmd_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            i_cmd_valid = 1'b0;
            k++;
        end while (!o_out_valid && k < 20);
        chk("rstmid_reached_emit", 32'(o_out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_out_ready = 1'b1;
        chk("rstmid_out_valid", 32'(o_out_valid), 32'd0);
        chk("rstmid_mem_addr", 32'(o_mem_addr), 32'h3FF);
        chk("rstmid_cmd_ready", 32'(o_cmd_ready), 32'd1);
        beats = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (o_out_valid || o_done) beats++;
        end
        chk("rstmid_silent", 32'(beats), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
